// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive buffer.
// The optional even-parity frame format is selected by UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [UART_BYTE_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO with power-of-two pointer wrap.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Head is read combinationally so the consumer can register it on the pop edge.
  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte FIFO
// that delivers one byte per uart_inbound strobe and waits for uart_done in between.
module uart_rx_buffer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          uart_done,
  output logic                          uart_inbound,
  output logic [UART_BYTE_W-1:0]        uart_data,
  output logic                          overrun,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

  logic                   sync1_q, sync2_q, prev_q;
  rx_state_e              state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_BYTE_W-1:0] shift_q, shift_d;
  logic                   bad_q, bad_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   inbound_q, inbound_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic                   awaiting_q, awaiting_d;
  logic                   tick;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_dout;
`ifdef UART_RX_PARITY_EN
  logic                   pe_q, pe_d;
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick = (timer_q == '0);

  // Receive FSM: every sample point is a timer expiry measured from the synced edge.
  always_comb begin
    state_d   = state_q;
    timer_d   = tick ? timer_q : timer_q - TMR_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bad_d     = bad_q;
    fe_d      = 1'b0;
    push      = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
          timer_d = TMR_HALF;
          bad_d   = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sync2_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            timer_d   = TMR_FULL;
            bit_cnt_d = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {sync2_q, shift_q[UART_BYTE_W-1:1]};
          timer_d = TMR_FULL;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          bad_d   = sync2_q ^ even_parity(shift_q);
          timer_d = TMR_FULL;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (!sync2_q) begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_IDLE;
          end else if (bad_q) begin
`ifdef UART_RX_PARITY_EN
            pe_d    = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      // A held-low line (break) must not retrigger once per bit time.
      ST_WAIT_IDLE: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delivery: a uart_done in the same cycle frees the slot so the next byte
  // is strobed in the following cycle.
  always_comb begin
    pop        = ~fifo_empty & (~awaiting_q | uart_done);
    ov_d       = push & fifo_full & ~pop;
    inbound_d  = pop;
    data_d     = pop ? fifo_dout : data_q;
    awaiting_d = awaiting_q;
    if (pop) begin
      awaiting_d = 1'b1;
    end else if (uart_done) begin
      awaiting_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      bad_q      <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      inbound_q  <= 1'b0;
      data_q     <= '0;
      awaiting_q <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      bad_q      <= bad_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      inbound_q  <= inbound_d;
      data_q     <= data_d;
      awaiting_q <= awaiting_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_q <= 1'b0;
    end else begin
      pe_q <= pe_d;
    end
  end
  assign parity_error = pe_q;
`else
  assign parity_error = 1'b0;
`endif

  assign uart_inbound  = inbound_q;
  assign uart_data     = data_q;
  assign overrun       = ov_q;
  assign framing_error = fe_q;

endmodule
